// File: rtl/data_distributor_stream.sv
// data_distributor_stream
//   Routes one input word per cycle into one of NUM_CH single-word holding
//   registers (unicast), or into all of them at once (broadcast).
//   Valid/ready handshakes are used on both sides. A word with an illegal
//   select is accepted and discarded, and each such drop is counted.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          when low, no new word is accepted (held words still drain)
//   flush           synchronous clear of every channel register
//   broadcast       the accepted word goes to every channel
//   select_line     target channel in unicast mode
//   in_valid        producer word valid
//   input_data      producer word
//   in_ready        combinational accept
//   out_valid[k]    channel k holds a word
//   out_ready[k]    consumer k takes the word
//   out_data        channel k in bits [k*DATA_WIDTH +: DATA_WIDTH]; reads 0 when empty
//   bad_select      one-cycle pulse per dropped word
//   drop_count      saturating count of dropped words
module data_distributor_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 4,
   parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic                         flush,
   input  logic                         broadcast,
   input  logic [SEL_WIDTH-1:0]         select_line,
   input  logic                         in_valid,
   input  logic [DATA_WIDTH-1:0]        input_data,
   output logic                         in_ready,
   output logic [NUM_CH-1:0]            out_valid,
   input  logic [NUM_CH-1:0]            out_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
   output logic                         bad_select,
   output logic [7:0]                   drop_count
);

   // The select field can encode more values than there are channels.
   // Padding can_take to the full select span keeps the index in range.
   localparam int SEL_SPAN = 1 << SEL_WIDTH;

   logic [NUM_CH-1:0]                 valid_q, valid_d;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_q, data_d;
   logic                              bad_select_q, bad_select_d;
   logic [7:0]                        drop_count_q, drop_count_d;

   logic [NUM_CH-1:0]   can_take;
   logic [SEL_SPAN-1:0] can_take_ext;
   logic                sel_legal;
   logic                xfer;

   always_comb begin
      can_take     = ~valid_q | out_ready;
      can_take_ext = '0;
      can_take_ext[NUM_CH-1:0] = can_take;
      sel_legal    = ({1'b0, select_line} < (SEL_WIDTH+1)'(NUM_CH));

      // Illegal unicast selects are always accepted so the producer never
      // stalls on them. Broadcast is all-or-nothing.
      if (!rst_n || !enable || flush)
         in_ready = 1'b0;
      else if (broadcast)
         in_ready = &can_take;
      else if (sel_legal)
         in_ready = can_take_ext[select_line];
      else
         in_ready = 1'b1;

      xfer = in_valid && in_ready;

      valid_d = valid_q;
      data_d  = data_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (flush) begin
            valid_d[k] = 1'b0;
            data_d[k]  = '0;
         end else if (xfer && (broadcast || (sel_legal && select_line == SEL_WIDTH'(k)))) begin
            // A load wins over a drain on the same edge.
            valid_d[k] = 1'b1;
            data_d[k]  = input_data;
         end else if (valid_q[k] && out_ready[k]) begin
            valid_d[k] = 1'b0;
            data_d[k]  = '0;
         end
      end

      bad_select_d = xfer && !broadcast && !sel_legal;
      drop_count_d = (bad_select_d && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= '0;
         data_q       <= '0;
         bad_select_q <= 1'b0;
         drop_count_q <= 8'd0;
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         bad_select_q <= bad_select_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_comb begin
      out_data = '0;
      for (int k = 0; k < NUM_CH; k++)
         out_data[k*DATA_WIDTH +: DATA_WIDTH] = valid_q[k] ? data_q[k] : '0;
   end

   assign out_valid  = valid_q;
   assign bad_select = bad_select_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_data_distributor_stream.sv
module tb_data_distributor_stream;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 4-channel instance
   logic        enable, flush, broadcast, in_valid, in_ready, bad_select;
   logic [1:0]  select_line;
   logic [7:0]  input_data, drop_count;
   logic [3:0]  out_valid, out_ready;
   logic [31:0] out_data;

   data_distributor_stream #(.DATA_WIDTH(8), .NUM_CH(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .broadcast(broadcast), .select_line(select_line), .in_valid(in_valid),
      .input_data(input_data), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .bad_select(bad_select),
      .drop_count(drop_count));

   // 3-channel instance (select value 3 is illegal)
   logic        b_enable, b_flush, b_broadcast, b_in_valid, b_in_ready, b_bad_select;
   logic [1:0]  b_select_line;
   logic [7:0]  b_input_data, b_drop_count;
   logic [2:0]  b_out_valid, b_out_ready;
   logic [23:0] b_out_data;

   data_distributor_stream #(.DATA_WIDTH(8), .NUM_CH(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(b_enable), .flush(b_flush),
      .broadcast(b_broadcast), .select_line(b_select_line), .in_valid(b_in_valid),
      .input_data(b_input_data), .in_ready(b_in_ready), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .bad_select(b_bad_select),
      .drop_count(b_drop_count));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model of the 4-channel instance: one word slot per channel.
   logic       mv [4];
   logic [7:0] md [4];
   int         mcnt;
   logic       mbad;

   task automatic model_clear();
      for (int k = 0; k < 4; k++) begin mv[k] = 1'b0; md[k] = 8'h00; end
      mcnt = 0;
      mbad = 1'b0;
   endtask

   function automatic logic model_ready();
      logic all_free;
      if (!enable || flush) return 1'b0;
      if (broadcast) begin
         all_free = 1'b1;
         for (int k = 0; k < 4; k++) if (mv[k] && !out_ready[k]) all_free = 1'b0;
         return all_free;
      end
      return !mv[select_line] || out_ready[select_line];
   endfunction

   task automatic compare_outputs();
      logic [3:0]  ev;
      logic [31:0] ed;
      ev = '0; ed = '0;
      for (int k = 0; k < 4; k++) begin
         ev[k] = mv[k];
         ed[k*8 +: 8] = mv[k] ? md[k] : 8'h00;
      end
      chk("out_valid", {28'd0, out_valid}, {28'd0, ev});
      chk("out_data", out_data, ed);
      chk("bad_select", {31'd0, bad_select}, {31'd0, mbad});
      chk("drop_count", {24'd0, drop_count}, mcnt);
   endtask

   // Entered just after a falling edge; leaves just after the next falling edge.
   task automatic step(input logic en, input logic fl, input logic bc, input logic [1:0] sel,
                       input logic iv, input logic [7:0] din, input logic [3:0] ordy);
      logic rdy, xfer;
      enable = en; flush = fl; broadcast = bc; select_line = sel;
      in_valid = iv; input_data = din; out_ready = ordy;
      #1;
      rdy = model_ready();
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      xfer = iv && rdy;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         if (fl) begin
            mv[k] = 1'b0; md[k] = 8'h00;
         end else if (xfer && (bc || sel == k[1:0])) begin
            mv[k] = 1'b1; md[k] = din;
         end else if (mv[k] && ordy[k]) begin
            mv[k] = 1'b0; md[k] = 8'h00;
         end
      end
      mbad = 1'b0;  // 4 channels: every select value is legal
      @(negedge clk);
      compare_outputs();
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 0; flush = 0; broadcast = 0; select_line = 0;
      in_valid = 0; input_data = 0; out_ready = 0;
      b_enable = 0; b_flush = 0; b_broadcast = 0; b_select_line = 0;
      b_in_valid = 0; b_input_data = 0; b_out_ready = 0;
      model_clear();

      // Reset state
      @(negedge clk); @(negedge clk);
      enable = 1; in_valid = 1; #1;
      chk("rst in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst out_valid", {28'd0, out_valid}, 32'd0);
      chk("rst out_data", out_data, 32'd0);
      chk("rst drop_count", {24'd0, drop_count}, 32'd0);
      chk("rst bad_select", {31'd0, bad_select}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Unicast A5 to channel 2, consumers all ready
      step(1, 0, 0, 2'd2, 1, 8'hA5, 4'b1111);
      chk("pin ch2 valid", {28'd0, out_valid}, 32'h4);
      chk("pin ch2 data", out_data, 32'h00A5_0000);
      step(1, 0, 0, 2'd2, 0, 8'h00, 4'b1111);
      chk("pin drained", {28'd0, out_valid}, 32'h0);

      // Channel 2 stalls holding A5; B5 waits, then replaces it on the drain edge
      step(1, 0, 0, 2'd2, 1, 8'hA5, 4'b1011);
      step(1, 0, 0, 2'd2, 1, 8'hB5, 4'b1011);
      chk("pin stall hold", out_data, 32'h00A5_0000);
      enable = 1; flush = 0; broadcast = 0; select_line = 2; in_valid = 1; out_ready = 4'b1011; #1;
      chk("pin stall in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      step(1, 0, 0, 2'd2, 1, 8'hB5, 4'b1111);
      chk("pin swap", out_data, 32'h00B5_0000);

      // Broadcast blocked by full channel 1, then delivered everywhere
      step(1, 0, 0, 2'd1, 1, 8'h11, 4'b1001);
      step(1, 0, 1, 2'd0, 1, 8'h3C, 4'b1101);
      step(1, 0, 1, 2'd0, 1, 8'h3C, 4'b1111);
      chk("pin broadcast", out_data, 32'h3C3C_3C3C);

      // Disabled: nothing accepted, held words still drain
      step(0, 0, 0, 2'd3, 1, 8'h77, 4'b0000);
      chk("pin disabled hold", out_data, 32'h3C3C_3C3C);
      step(0, 0, 0, 2'd3, 1, 8'h77, 4'b1111);
      chk("pin disabled drain", {28'd0, out_valid}, 32'h0);

      // Fill every channel, then flush with a word offered
      step(1, 0, 1, 2'd0, 1, 8'h5A, 4'b0000);
      step(1, 1, 0, 2'd1, 1, 8'h99, 4'b1111);
      chk("pin flush", {28'd0, out_valid}, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom));

      // Asynchronous reset mid-stream
      step(1, 0, 1, 2'd0, 1, 8'hC3, 4'b0000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async out_valid", {28'd0, out_valid}, 32'h0);
      chk("async out_data", out_data, 32'h0);
      chk("async in_ready", {31'd0, in_ready}, 32'd0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0, 2'd0, 1, 8'h42, 4'b1111);
      chk("pin after reset", out_data, 32'h0000_0042);

      // 3-channel instance: 300 illegal selects, count saturates at 255
      in_valid = 0; enable = 0;
      b_enable = 1; b_select_line = 2'd3; b_in_valid = 1; b_out_ready = 3'b000;
      for (int i = 0; i < 300; i++) begin
         b_input_data = 8'($urandom);
         #1;
         chk("b in_ready", {31'd0, b_in_ready}, 32'd1);
         @(negedge clk);
         chk("b bad_select", {31'd0, b_bad_select}, 32'd1);
         chk("b drop_count", {24'd0, b_drop_count}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
         chk("b out_valid", {29'd0, b_out_valid}, 32'd0);
      end
      b_in_valid = 0;
      @(negedge clk);
      chk("b bad_select end", {31'd0, b_bad_select}, 32'd0);
      chk("b drop_count held", {24'd0, b_drop_count}, 32'd255);
      b_select_line = 2'd2; b_input_data = 8'h5A; b_in_valid = 1;
      @(negedge clk);
      b_in_valid = 0;
      chk("b legal valid", {29'd0, b_out_valid}, 32'h4);
      chk("b legal data", {8'd0, b_out_data}, 32'h005A_0000);
      chk("b legal no drop", {31'd0, b_bad_select}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
